// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operation/result bundle between ID/EX and the ALU/MDU.
// master = issuing pipeline, slave = execute unit.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            illegal_op;

  modport master (
    output in_valid,
    output alu_op,
    output funct3,
    output funct7,
    output op_a,
    output op_b,
    input  in_ready,
    input  out_valid,
    input  result,
    input  illegal_op
  );

  modport slave (
    input  in_valid,
    input  alu_op,
    input  funct3,
    input  funct7,
    input  op_a,
    input  op_b,
    output in_ready,
    output out_valid,
    output result,
    output illegal_op
  );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: RV32I ALU (1-cycle) plus iterative mul/div unit.
// M extension is compiled only when RV_M_EXT_EN is defined.
module alu_mdu_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  alu_mdu_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MUL  = 7'h01;

  generate
    if ((XLEN % 2 != 0) || (XLEN < 8) ||
        ((1 << CNT_W) <= XLEN)) begin : g_bad_cfg
      $error("alu_mdu_ctrl: bad XLEN/CNT_W");
    end
  endgenerate

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR,
    K_SRL, K_SRA, K_OR, K_AND, K_MUL, K_ILL
  } kind_t;

  function automatic kind_t base_kind(
    input logic [2:0] f3
  );
    kind_t k;
    unique case (f3)
      3'b000: k = K_ADD;
      3'b001: k = K_SLL;
      3'b010: k = K_SLT;
      3'b011: k = K_SLTU;
      3'b100: k = K_XOR;
      3'b101: k = K_SRL;
      3'b110: k = K_OR;
      3'b111: k = K_AND;
    endcase
    return k;
  endfunction

  kind_t           kind;
  logic            f7_base;
  logic            f7_alt;
  logic            f7_mul;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            in_ready;
  logic            accept;
  logic            acc_alu;
  logic            out_valid_q;
  logic            illegal_q;
  logic [XLEN-1:0] result_q;
  logic            fix_fire;
  logic [XLEN-1:0] m_res;

  assign f7_base = (bus.funct7 == F7_BASE);
  assign f7_alt  = (bus.funct7 == F7_ALT);
  assign f7_mul  = (bus.funct7 == F7_MUL);
  assign shamt   = bus.op_b[SHW-1:0];

  // operation decode from alu_op/funct3/funct7
  always_comb begin
    kind = K_ILL;
    unique case (bus.alu_op)
      2'b00: kind = K_ADD;
      2'b01: kind = K_SUB;
      2'b10: begin
        unique case (1'b1)
          f7_base:
            kind = base_kind(bus.funct3);
          f7_alt && (bus.funct3 == 3'b000):
            kind = K_SUB;
          f7_alt && (bus.funct3 == 3'b101):
            kind = K_SRA;
`ifdef RV_M_EXT_EN
          f7_mul:
            kind = K_MUL;
`endif
          default:
            kind = K_ILL;
        endcase
      end
      2'b11: begin
        unique case (bus.funct3)
          3'b001:
            kind = f7_base ? K_SLL : K_ILL;
          3'b101:
            kind = f7_base ? K_SRL :
                   (f7_alt ? K_SRA : K_ILL);
          default:
            kind = base_kind(bus.funct3);
        endcase
      end
    endcase
  end

  // single-cycle datapath; illegal and M kinds give zero
  always_comb begin
    alu_res = '0;
    unique case (kind)
      K_ADD:  alu_res = bus.op_a + bus.op_b;
      K_SUB:  alu_res = bus.op_a - bus.op_b;
      K_SLL:  alu_res = bus.op_a << shamt;
      K_SLT:  alu_res = {{(XLEN-1){1'b0}},
                         $signed(bus.op_a) <
                         $signed(bus.op_b)};
      K_SLTU: alu_res = {{(XLEN-1){1'b0}},
                         bus.op_a < bus.op_b};
      K_XOR:  alu_res = bus.op_a ^ bus.op_b;
      K_SRL:  alu_res = bus.op_a >> shamt;
      K_SRA:  alu_res = $unsigned(
                $signed(bus.op_a) >>> shamt);
      K_OR:   alu_res = bus.op_a | bus.op_b;
      K_AND:  alu_res = bus.op_a & bus.op_b;
      default: alu_res = '0;
    endcase
  end

  assign accept  = bus.in_valid & in_ready & ~flush;
  assign acc_alu = accept & (kind != K_MUL);

`ifdef RV_M_EXT_EN
  typedef enum logic [1:0] {
    S_IDLE, S_PREP, S_ITER, S_FIX
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              last_it;
  logic              acc_m;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   d_q;
  logic [XLEN-1:0]   p_hi;
  logic [XLEN-1:0]   p_lo;
  logic              neg_a;
  logic              neg_b;
  logic              sa;
  logic              sb;
  logic              sgn_a;
  logic              sgn_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_tr;
  logic [2*XLEN-1:0] step_nx;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic              b_zero;
  logic              ovf;

  assign acc_m   = accept & (kind == K_MUL);
  assign last_it = (cnt == CNT_W'(XLEN-1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state; flush always returns to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (acc_m) state_nx = S_PREP;
      S_PREP: state_nx = S_ITER;
      S_ITER: if (last_it) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // FSM outputs
  always_comb begin
    in_ready = (state == S_IDLE) & ~flush;
    fix_fire = (state == S_FIX) & ~flush;
  end

  // iteration counter, 0..XLEN-1 while in ITER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if ((state == S_ITER) && !last_it)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  // operand signedness and magnitudes
  always_comb begin
    unique case (f3_q)
      3'b001, 3'b100, 3'b110: {sa, sb} = 2'b11;
      3'b010:                 {sa, sb} = 2'b10;
      default:                {sa, sb} = 2'b00;
    endcase
    sgn_a = sa & a_q[XLEN-1];
    sgn_b = sb & b_q[XLEN-1];
    abs_a = sgn_a ? -a_q : a_q;
    abs_b = sgn_b ? -b_q : b_q;
  end

  // one shift-add or restoring shift-subtract step
  always_comb begin
    mul_sum = {1'b0, p_hi} +
              (p_lo[0] ? {1'b0, d_q} : '0);
    div_sh  = {p_hi, p_lo[XLEN-1]};
    div_tr  = div_sh - {1'b0, d_q};
    if (!f3_q[2])
      step_nx = {mul_sum, p_lo[XLEN-1:1]};
    else if (!div_tr[XLEN])
      step_nx = {div_tr[XLEN-1:0],
                 p_lo[XLEN-2:0], 1'b1};
    else
      step_nx = {div_sh[XLEN-1:0],
                 p_lo[XLEN-2:0], 1'b0};
  end

  // latch at accept, set up in PREP, iterate in ITER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      d_q   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else if (acc_m) begin
      a_q  <= bus.op_a;
      b_q  <= bus.op_b;
      f3_q <= bus.funct3;
    end else if (state == S_PREP) begin
      neg_a <= sgn_a;
      neg_b <= sgn_b;
      d_q   <= f3_q[2] ? abs_b : abs_a;
      p_hi  <= '0;
      p_lo  <= f3_q[2] ? abs_a : abs_b;
    end else if (state == S_ITER) begin
      {p_hi, p_lo} <= step_nx;
    end
  end

  // sign fix-up, special divides, result select
  always_comb begin
    prod   = {p_hi, p_lo};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    quo    = (neg_a ^ neg_b) ? -p_lo : p_lo;
    rem    = neg_a ? -p_hi : p_hi;
    b_zero = (b_q == '0);
    ovf    = ~f3_q[0] & (a_q == MIN_NEG) & (&b_q);
    if (b_zero) begin
      quo = '1;
      rem = a_q;
    end else if (ovf) begin
      quo = a_q;
      rem = '0;
    end
    unique case (f3_q)
      3'b000:
        m_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011:
        m_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:
        m_res = quo;
      default:
        m_res = rem;
    endcase
  end
`else
  assign in_ready = ~flush;
  assign fix_fire = 1'b0;
  assign m_res    = '0;
`endif

  // result register; out_valid is a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
    end else if (acc_alu) begin
      out_valid_q <= 1'b1;
      illegal_q   <= (kind == K_ILL);
      result_q    <= alu_res;
    end else if (fix_fire) begin
      out_valid_q <= 1'b1;
      illegal_q   <= 1'b0;
      result_q    <= m_res;
    end else begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.illegal_op = illegal_q;
  assign bus.result     = result_q;
endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
Parametrised execute-stage ALU control and datapath for the five-stage pipeline.
- Decodes the full RV32I ALU operation set from alu_op/funct3/funct7 and executes it with a registered 1-cycle result.
- Adds an iterative multiply/divide unit (RV M extension) with a valid/ready handshake.
- The pipeline stalls ID/EX on in_ready low and consumes the result when out_valid is high.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush; aborts any in-flight operation.
- in_valid  input  1  operation present.
- in_ready  output  1  unit can accept an operation.
- alu_op  input  2  00 ADD (address), 01 SUB (branch compare), 10 R-type, 11 I-type.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7 (for I-type shifts, imm[11:5]).
- op_a  input  XLEN  operand A.
- op_b  input  XLEN  operand B (or sign-extended immediate).
- out_valid  output  1  result valid; one-cycle pulse.
- result  output  XLEN  operation result.
- illegal_op  output  1  pulses together with out_valid when the encoding is undefined.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, out_valid 0, result 0, illegal_op 0, counter 0. in_ready is 1 once reset deasserts.
- Accept condition: in_valid & in_ready & ~flush. in_ready = (state == IDLE) & ~flush.
- Decode:
  - alu_op 00 gives ADD; 01 gives SUB.
  - 10 with funct7 0000000 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3.
  - 10 with funct7 0100000 gives SUB (funct3 000) or SRA (funct3 101).
  - 10 with funct7 0000001 gives an M operation: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by funct3.
  - 11: funct7 is ignored except for shifts. funct3 001 requires funct7 0000000; funct3 101 requires 0000000 (SRLI) or 0100000 (SRAI).
  - Every other combination is illegal: result 0 and illegal_op 1.
- Shift amount is op_b[log2(XLEN)-1:0].
- SLT/SLTU results are zero-extended to XLEN bits.
- Single-cycle ops (including illegal): result/out_valid are registered on the accept edge and visible the next cycle. Latency 1, back-to-back throughput; state stays IDLE.
- M ops use the FSM IDLE -> PREP -> ITER -> FIX -> IDLE:
  - PREP (1 cycle): captures absolute values and sign flags. Signedness: MULH both operands signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned; MUL sign-agnostic.
  - ITER (exactly XLEN cycles): radix-2 shift-add for multiply into a 2*XLEN product; restoring shift-subtract for divide. The counter runs from 0 to XLEN-1.
  - FIX (1 cycle): sign correction, then low/high product half or quotient/remainder select. result and out_valid are registered here.
  - Fixed latency: out_valid is high in the cycle XLEN+3 after the accept edge, for every M op including special cases.
  - in_ready is low from the accept edge until state returns to IDLE. A new op is acceptable in the cycle out_valid is high.
- Divide special cases, resolved in FIX while keeping fixed latency:
  - Divisor 0: quotient all-ones; remainder = op_a.
  - Signed overflow (op_a = -2^(XLEN-1), op_b = -1): quotient = op_a; remainder 0.
- Sign rules: remainder takes the dividend's sign. Quotient is negated when the operand signs differ and the divisor is nonzero.
- Operand latching: operands are captured at accept; later changes on op_a/op_b have no effect.
- Flush:
  - Takes effect next cycle: state IDLE, no out_valid for the aborted op; result holds its previous value.
  - flush together with in_valid means the op is not accepted.
  - flush in the same cycle a FIX edge would occur suppresses that out_valid.
- Reset mid-operation: immediate return to reset values; the in-flight op is lost.
- out_valid has no backpressure. The consumer must take the result in the pulse cycle.

Optional Feature:
- RV_M_EXT_EN defined: M ops are implemented as above.
- RV_M_EXT_EN undefined:
  - PREP/ITER/FIX and their datapath are not compiled.
  - funct7 0000001 with alu_op 10 is illegal: latency 1, result 0, illegal_op 1.
  - in_ready = ~flush permanently.

Test Plan:
- Reset then R-type SUB (funct7 0100000, funct3 000), A=5, B=7 -> next cycle out_valid=1, result=0xFFFFFFFE, illegal_op=0; back-to-back SRAI A=0x80000000, shamt 4 -> result 0xF8000000.
- MULH A=0xFFFFFFFF (-1), B=0x00000002 -> in_ready low for 34 cycles; out_valid in cycle 35 after accept, result 0xFFFFFFFF; MUL same operands -> 0xFFFFFFFE.
- DIV A=0x80000000, B=0xFFFFFFFF -> result 0x80000000; REM -> 0; DIVU A=100, B=0 -> 0xFFFFFFFF; REMU -> 100; all at latency 35.
- REM A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD.
- DIVU accepted, flush asserted on cycle 10 -> no out_valid ever; in_ready high cycle 11; new ADD 3+4 accepted -> result 7 next cycle.
- I-type funct3 001 with funct7 0000001 -> illegal_op=1, result 0; RV_M_EXT_EN undefined, R-type MUL -> illegal_op=1 at latency 1.
